fb_fill_writer: RTL

Wishbone B3 burst-write master that fills the DDR2 frame buffer with a color-bar test pattern, then holds `fill_done` high. It is the writer end of the frame-buffer path: it drives the same DDR2 Wishbone slave that the display pipeline reads from. `fill_done` gates the display reset until the buffer holds a complete frame.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_fill_writer_if.sv | 18 +
 rtl/fb_pattern_gen.sv | 39 +++
 rtl/fb_fill_writer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the frame-buffer fill path.
//   fb_state_e : writer FSM states
//   CTI_*      : Wishbone B3 cycle-type identifiers used by the burst writer
//   BAR_COLOR  : 24-bit RGB per color bar, index 0 = leftmost bar
package fb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP, ST_DONE} fb_state_e;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  // c = 7 - bar, R = c[1], G = c[2], B = c[0]:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][23:0] BAR_COLOR = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/fb_fill_writer_if.sv
// fb_fill_writer_if: Wishbone B3 master bus bundle for the frame-buffer writer.
//   adr/dat/sel/we/cyc/stb/cti/bte : master -> slave
//   ack/err                        : slave -> master
interface fb_fill_writer_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (output adr, dat, sel, we, cyc, stb, cti, bte, input ack, err);
  modport slave  (input adr, dat, sel, we, cyc, stb, cti, bte, output ack, err);
endinterface

// File: rtl/fb_pattern_gen.sv
// fb_pattern_gen: combinational pixel word for the color-bar test pattern.
//   x, y : pixel coordinates
//   bar  : running bar number (0..7) maintained by the writer
//   pix  : {8'h00, R, G, B}
// Build option FB_FILL_GRID_EN overlays a white 32-pixel grid plus a
// one-pixel frame border.
module fb_pattern_gen
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar,
  output logic [31:0]   pix
);

`ifdef FB_FILL_GRID_EN
  logic [31:0] xe, ye;
  assign xe = 32'(x);
  assign ye = 32'(y);

  always_comb begin
    pix = {8'h00, BAR_COLOR[bar]};
    if (xe[4:0] == 5'd0 || ye[4:0] == 5'd0 ||
        xe == 32'(H_ACTIVE - 1) || ye == 32'(V_ACTIVE - 1))
      pix = 32'h00FF_FFFF;
  end
`else
  // Coordinates only matter for the grid overlay.
  logic unused_xy;
  assign unused_xy = ^{x, y};
  assign pix       = {8'h00, BAR_COLOR[bar]};
`endif

endmodule

// File: rtl/fb_fill_writer.sv
// fb_fill_writer: Wishbone B3 burst-write master that fills the frame buffer
// with color bars, then holds fill_done.
//   wb_clk, wb_rst_n : clock, async active-low reset
//   start            : one-cycle pulse, begins a fill from IDLE or DONE
//   wbm              : Wishbone master (incrementing bursts of BURST_LEN)
//   fill_done        : complete frame written
//   busy             : fill in progress (BURST or GAP)
//   err_cnt          : bursts aborted by err, saturating at 255
// Build option FB_FILL_GRID_EN (in fb_pattern_gen) adds an alignment grid.
module fb_fill_writer
  import fb_pkg::*;
#(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic                    start,
  fb_fill_writer_if.master        wbm,
  output logic                    fill_done,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE + 1);
  localparam int BW    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int PW    = $clog2(BW + 1);
  localparam int CW    = $clog2(BURST_LEN + 1);

  // Scan position; bar/pos replace x / BW with a running counter.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    bar;
    logic [PW-1:0] pos;
  } pos_t;

  function automatic pos_t advance(pos_t p);
    pos_t n;
    n     = p;
    n.idx = p.idx + 1'b1;
    if (p.x == XW'(H_ACTIVE - 1)) begin
      n.x   = '0;
      n.y   = p.y + 1'b1;
      n.bar = '0;
      n.pos = '0;
    end else begin
      n.x = p.x + 1'b1;
      if (p.pos == PW'(BW - 1)) begin
        n.pos = '0;
        if (p.bar != 3'd7) n.bar = p.bar + 1'b1;  // clamp for widths not divisible by 8
      end else begin
        n.pos = p.pos + 1'b1;
      end
    end
    return n;
  endfunction

  fb_state_e   state_q, state_d;
  pos_t        cur_q, cur_d;
  pos_t        snap_q, snap_d;      // first pixel of the current burst, for retry
  logic [CW-1:0] beat_q, beat_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        fill_done_q, fill_done_d;
  logic        busy_q, busy_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [2:0]  cti_q, cti_d;
  logic [31:0] pix_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    snap_d      = snap_q;
    beat_d      = beat_q;
    err_cnt_d   = err_cnt_q;
    fill_done_d = fill_done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_BURST;
          cur_d       = '0;
          snap_d      = '0;
          beat_d      = '0;
          fill_done_d = 1'b0;
        end
      end
      ST_BURST: begin
        // err wins over a simultaneous ack
        if (wbm.err) begin
          state_d = ST_GAP;
          cur_d   = snap_q;
          beat_d  = '0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (wbm.ack) begin
          cur_d = advance(cur_q);
          if (beat_q == CW'(BURST_LEN - 1)) begin
            beat_d = '0;
            snap_d = advance(cur_q);
            if (cur_q.idx == IW'(TOTAL - 1)) begin
              state_d     = ST_DONE;
              fill_done_d = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_GAP:  state_d = ST_BURST;
      default: state_d = ST_IDLE;
    endcase
  end

  fb_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pat (
    .x   (cur_d.x),
    .y   (cur_d.y),
    .bar (cur_d.bar),
    .pix (pix_d)
  );

  // Bus outputs are registered from next-state, so adr/dat move only on
  // the edge that consumes an ack and are zero whenever the bus is idle.
  assign cyc_d  = (state_d == ST_BURST);
  assign busy_d = (state_d == ST_BURST) || (state_d == ST_GAP);
  assign adr_d  = cyc_d ? BASE_ADDR + (32'(cur_d.idx) << 2) : 32'h0;
  assign dat_d  = cyc_d ? pix_d : 32'h0;
  assign cti_d  = !cyc_d ? 3'b000 :
                  (beat_d == CW'(BURST_LEN - 1)) ? CTI_END : CTI_INCR;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      snap_q      <= '0;
      beat_q      <= '0;
      err_cnt_q   <= '0;
      fill_done_q <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      cti_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      snap_q      <= snap_d;
      beat_q      <= beat_d;
      err_cnt_q   <= err_cnt_d;
      fill_done_q <= fill_done_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cti_q       <= cti_d;
    end
  end

  assign wbm.adr  = adr_q;
  assign wbm.dat  = dat_q;
  assign wbm.sel  = {4{cyc_q}};
  assign wbm.we   = cyc_q;
  assign wbm.cyc  = cyc_q;
  assign wbm.stb  = cyc_q;
  assign wbm.cti  = cti_q;
  assign wbm.bte  = 2'b00;
  assign fill_done = fill_done_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule
